seg_scan_driver: RTL

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display, producing `eSeg`/`anode` from four hex digits plus per-digit dot, blank and blink controls. It is the output end of the display interface that `Main` presents at the top level: every service (clock, alarm, stopwatch, mini-game) writes its digits here, and the block turns them into the scanned segment and anode signals. Each frame starts from a snapshot of the inputs, so a frame never mixes old and new values. Blanking gaps between digits suppress ghosting.

---
 rtl/seg_scan_driver_pkg.sv | 22 ++
 rtl/seg_scan_driver_if.sv | 12 +
 rtl/seg_hex_decode.sv | 30 +++
 rtl/seg_scan_driver.sv | 107 ++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: shared segment constants and scan FSM state type
package seg_scan_driver_pkg;
    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'hF;
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: digit/control inputs and scanned segment/anode outputs
interface seg_scan_driver_if;
    logic [15:0] digits;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [7:0]  eSeg;
    logic [3:0]  anode;
    logic        frame_tick;
    modport master (output digits, dots, blank, blink, input eSeg, anode, frame_tick);
    modport slave  (input digits, dots, blank, blink, output eSeg, anode, frame_tick);
endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational nibble to active-low g..a segment pattern
module seg_hex_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    logic [7:0] w_pat;
    always_comb begin
        case (i_nib)
            4'h0: w_pat = SEG_0;
            4'h1: w_pat = SEG_1;
            4'h2: w_pat = SEG_2;
            4'h3: w_pat = SEG_3;
            4'h4: w_pat = SEG_4;
            4'h5: w_pat = SEG_5;
            4'h6: w_pat = SEG_6;
            4'h7: w_pat = SEG_7;
            4'h8: w_pat = SEG_8;
            4'h9: w_pat = SEG_9;
            4'hA: w_pat = SEG_A;
            4'hB: w_pat = SEG_B;
            4'hC: w_pat = SEG_C;
            4'hD: w_pat = SEG_D;
            4'hE: w_pat = SEG_E;
            default: w_pat = SEG_F;
        endcase
    end
    assign o_seg = w_pat[6:0];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 4-digit common-anode display scanner
// with per-frame input snapshot, blanking gaps, dots, blank and blink.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int DIGIT_TICKS  = 100000,
    parameter int BLANK_TICKS  = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input logic clk_osc,
    input logic rst_n,
    seg_scan_driver_if.slave bus
);
    localparam int DW = $clog2(DIGIT_TICKS + 1);
    localparam int BW = $clog2(BLANK_TICKS + 1);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DIGIT_TICKS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLANK_TICKS - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    state_t        r_state, w_state_n;
    logic [1:0]    r_idx, w_idx_n;
    logic [DW-1:0] r_dcnt, w_dcnt_n;
    logic [BW-1:0] r_bcnt, w_bcnt_n;
    logic [FW-1:0] r_fcnt;
    logic          r_phase;
    logic [15:0]   r_digits, w_digits;
    logic [3:0]    r_dots, r_blank, r_blink, w_dots, w_blank, w_blink;
    logic [7:0]    r_eseg, w_eseg_n;
    logic [3:0]    r_anode, w_anode_n;
    logic          r_frame_tick, w_frame_tick_n;
    logic          w_snap, w_dark;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_dcnt_n  = r_dcnt;
        w_bcnt_n  = r_bcnt;
        if (r_state == ST_BLANK) begin
            if (r_bcnt == B_LAST) begin
                w_state_n = ST_DRIVE;
                w_bcnt_n  = '0;
            end else
                w_bcnt_n = r_bcnt + 1'b1;
        end else if (r_dcnt == D_LAST) begin
            w_state_n = ST_BLANK;
            w_dcnt_n  = '0;
            w_idx_n   = r_idx - 2'd1;
        end else
            w_dcnt_n = r_dcnt + 1'b1;
    end

    // Snapshot values are forwarded so a 1-cycle blank gap still shows the new frame.
    assign w_snap   = (r_state == ST_BLANK) && (r_idx == 2'd3) && (r_bcnt == '0);
    assign w_digits = w_snap ? bus.digits : r_digits;
    assign w_dots   = w_snap ? bus.dots   : r_dots;
    assign w_blank  = w_snap ? bus.blank  : r_blank;
    assign w_blink  = w_snap ? bus.blink  : r_blink;
    assign w_nib    = w_digits[{w_idx_n, 2'b00} +: 4];
    assign w_dark   = w_blank[w_idx_n] | (w_blink[w_idx_n] & ~r_phase);

    seg_hex_decode u_dec (.i_nib(w_nib), .o_seg(w_seg));

    assign w_eseg_n       = (w_state_n == ST_BLANK || w_dark) ? SEG_OFF : {~w_dots[w_idx_n], w_seg};
    assign w_anode_n      = (w_state_n == ST_BLANK) ? ANODE_OFF : ~(4'b0001 << w_idx_n);
    assign w_frame_tick_n = (w_state_n == ST_DRIVE) && (w_idx_n == 2'd0) && (w_dcnt_n == D_LAST);

    always_ff @(posedge clk_osc) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_idx        <= 2'd3;
            r_dcnt       <= '0;
            r_bcnt       <= '0;
            r_fcnt       <= '0;
            r_phase      <= 1'b1;
            r_digits     <= '0;
            r_dots       <= '0;
            r_blank      <= '0;
            r_blink      <= '0;
            r_eseg       <= SEG_OFF;
            r_anode      <= ANODE_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_idx        <= w_idx_n;
            r_dcnt       <= w_dcnt_n;
            r_bcnt       <= w_bcnt_n;
            r_digits     <= w_digits;
            r_dots       <= w_dots;
            r_blank      <= w_blank;
            r_blink      <= w_blink;
            r_eseg       <= w_eseg_n;
            r_anode      <= w_anode_n;
            r_frame_tick <= w_frame_tick_n;
            if (r_frame_tick) begin
                r_fcnt <= (r_fcnt == F_LAST) ? '0 : r_fcnt + 1'b1;
                if (r_fcnt == F_LAST) r_phase <= ~r_phase;
            end
        end
    end

    assign bus.eSeg       = r_eseg;
    assign bus.anode      = r_anode;
    assign bus.frame_tick = r_frame_tick;
endmodule
